lcd_write_scheduler: RTL

Shared controller for the 4-bit HD44780-style character LCD driven by the clock design. Arbitrates byte-write requests from two requesters: the time/timer/alarm digit refresher and the mode/status writer. Serialises each accepted byte into two enable-pulsed nibbles with fixed timing, and inserts the long settle delay after clear/home commands. Optionally runs the LCD power-on init sequence before accepting traffic.

---
 rtl/lcd_write_scheduler.sv | 283 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/lcd_write_scheduler.sv
// lcd_write_scheduler
//   Shared 4-bit HD44780-style LCD write engine. Two requesters (req0: digit
//   refresher, req1: mode/status writer) compete for the bus through
//   round-robin arbitration. Each accepted byte goes out as two nibbles. Each
//   nibble holds en high for EN_CYCLES and then low for GAP_CYCLES. After a
//   clear (0x01) or home (0x02) command the engine waits LONG_WAIT more cycles.
//
//   Optional feature: define LCD_SCHED_INIT_SEQ_EN to run the LCD power-on
//   init sequence (nibbles 3,3,3,2 then bytes 28,0C,06,01) after the startup
//   wait and before any requester is served.
//
//   Ports
//     clk, rst                 : clock, asynchronous active-high reset
//     reqN_valid/rs/data/ready : byte-write request handshake, N = 0,1
//     rs, en, data[3:0]        : LCD pins (data is LCD D7..D4)
//     busy                     : high whenever the engine is not idle
//     init_done                : high once startup is complete, until reset
module lcd_write_scheduler #(
  parameter int unsigned EN_CYCLES  = 800,
  parameter int unsigned GAP_CYCLES = 800,
  parameter int unsigned LONG_WAIT  = 60000,
  parameter int unsigned INIT_WAIT  = 12000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  input  logic       req0_rs,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic       req1_rs,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  output logic       rs,
  output logic       en,
  output logic [3:0] data,
  output logic       busy,
  output logic       init_done
);

  typedef enum logic [2:0] {
    S_WAIT   = 3'd0,
`ifdef LCD_SCHED_INIT_SEQ_EN
    S_INIT   = 3'd1,
`endif
    S_IDLE   = 3'd2,
    S_HI_EN  = 3'd3,
    S_HI_GAP = 3'd4,
    S_LO_EN  = 3'd5,
    S_LO_GAP = 3'd6,
    S_HOLD   = 3'd7
  } state_t;

  // Terminal counts of the shared cycle counter.
  localparam logic [31:0] INIT_LAST = 32'(INIT_WAIT);
  localparam logic [31:0] EN_LAST   = 32'(EN_CYCLES - 1);
  localparam logic [31:0] GAP_LAST  = 32'(GAP_CYCLES - 1);
  localparam logic [31:0] LONG_LAST = 32'(LONG_WAIT - 1);

  state_t      state_reg, state_next;
  logic [31:0] cnt_reg, cnt_next;
  logic [7:0]  byte_reg, byte_next;
  logic        rs_lat_reg, rs_lat_next;
  logic        ptr_reg, ptr_next;       // 1: req1 wins the next tie
  logic        rs_reg, rs_next;
  logic        en_reg, en_next;
  logic [3:0]  data_reg, data_next;
  logic        busy_reg, busy_next;
  logic        init_done_reg, init_done_next;
  logic        item_done;
  logic        grant0, grant1;

`ifdef LCD_SCHED_INIT_SEQ_EN
  logic [3:0]  init_idx_reg, init_idx_next;
  logic        single_reg, single_next;   // current item is a lone high nibble

  // The first four items are single nibbles, carried in the upper half.
  function automatic logic [7:0] init_item(input logic [3:0] idx);
    case (idx)
      4'd0, 4'd1, 4'd2: init_item = 8'h30;
      4'd3:             init_item = 8'h20;
      4'd4:             init_item = 8'h28;
      4'd5:             init_item = 8'h0C;
      4'd6:             init_item = 8'h06;
      default:          init_item = 8'h01;
    endcase
  endfunction
`endif

  // On a tie the requester favoured by the pointer takes the grant. Only the
  // losing side sees ready low, so at most one grant can happen per cycle.
  assign req0_ready = (state_reg == S_IDLE) && !(req1_valid && ptr_reg);
  assign req1_ready = (state_reg == S_IDLE) && !(req0_valid && !ptr_reg);
  assign grant0     = req0_ready && req0_valid;
  assign grant1     = req1_ready && req1_valid;

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    byte_next      = byte_reg;
    rs_lat_next    = rs_lat_reg;
    ptr_next       = ptr_reg;
    rs_next        = rs_reg;
    en_next        = en_reg;
    data_next      = data_reg;
    init_done_next = init_done_reg;
    item_done      = 1'b0;
`ifdef LCD_SCHED_INIT_SEQ_EN
    init_idx_next  = init_idx_reg;
    single_next    = single_reg;
`endif

    case (state_reg)
      S_WAIT: begin
        if (cnt_reg == INIT_LAST) begin
          cnt_next = '0;
`ifdef LCD_SCHED_INIT_SEQ_EN
          state_next    = S_INIT;
          init_idx_next = '0;
`else
          state_next     = S_IDLE;
          init_done_next = 1'b1;
`endif
        end else begin
          cnt_next = cnt_reg + 32'd1;
        end
      end

`ifdef LCD_SCHED_INIT_SEQ_EN
      S_INIT: begin
        byte_next     = init_item(init_idx_reg);
        single_next   = (init_idx_reg < 4'd4);
        rs_lat_next   = 1'b0;
        init_idx_next = init_idx_reg + 4'd1;
        state_next    = S_HI_EN;
        cnt_next      = '0;
        en_next       = 1'b1;
        rs_next       = 1'b0;
        data_next     = byte_next[7:4];
      end
`endif

      S_IDLE: begin
        if (grant0 || grant1) begin
          byte_next   = grant1 ? req1_data : req0_data;
          rs_lat_next = grant1 ? req1_rs : req0_rs;
          ptr_next    = grant0;   // the other side wins the next tie
          state_next  = S_HI_EN;
          cnt_next    = '0;
          en_next     = 1'b1;
          rs_next     = rs_lat_next;
          data_next   = byte_next[7:4];
`ifdef LCD_SCHED_INIT_SEQ_EN
          single_next = 1'b0;
`endif
        end
      end

      S_HI_EN: begin
        if (cnt_reg == EN_LAST) begin
          state_next = S_HI_GAP;
          cnt_next   = '0;
          en_next    = 1'b0;
        end else begin
          cnt_next = cnt_reg + 32'd1;
        end
      end

      S_HI_GAP: begin
        if (cnt_reg == GAP_LAST) begin
          cnt_next = '0;
`ifdef LCD_SCHED_INIT_SEQ_EN
          if (single_reg) item_done = 1'b1;
          else
`endif
          begin
            state_next = S_LO_EN;
            en_next    = 1'b1;
            data_next  = byte_reg[3:0];
          end
        end else begin
          cnt_next = cnt_reg + 32'd1;
        end
      end

      S_LO_EN: begin
        if (cnt_reg == EN_LAST) begin
          state_next = S_LO_GAP;
          cnt_next   = '0;
          en_next    = 1'b0;
        end else begin
          cnt_next = cnt_reg + 32'd1;
        end
      end

      S_LO_GAP: begin
        if (cnt_reg == GAP_LAST) begin
          cnt_next = '0;
          // Clear and home need the long settle time on the LCD side.
          if (!rs_lat_reg && (byte_reg == 8'h01 || byte_reg == 8'h02))
            state_next = S_HOLD;
          else
            item_done = 1'b1;
        end else begin
          cnt_next = cnt_reg + 32'd1;
        end
      end

      S_HOLD: begin
        if (cnt_reg == LONG_LAST) begin
          cnt_next  = '0;
          item_done = 1'b1;
        end else begin
          cnt_next = cnt_reg + 32'd1;
        end
      end

      default: begin
        state_next = S_WAIT;
        cnt_next   = '0;
        en_next    = 1'b0;
      end
    endcase

    // A finished item returns to IDLE, or to the next init step while the
    // power-on sequence is still running.
    if (item_done) begin
`ifdef LCD_SCHED_INIT_SEQ_EN
      if (!init_done_reg && init_idx_reg != 4'd8) begin
        state_next = S_INIT;
      end else begin
        state_next     = S_IDLE;
        init_done_next = 1'b1;
      end
`else
      state_next = S_IDLE;
`endif
    end

    busy_next = (state_next != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= S_WAIT;
      cnt_reg       <= '0;
      byte_reg      <= '0;
      rs_lat_reg    <= 1'b0;
      ptr_reg       <= 1'b1;
      rs_reg        <= 1'b0;
      en_reg        <= 1'b0;
      data_reg      <= '0;
      busy_reg      <= 1'b1;
      init_done_reg <= 1'b0;
`ifdef LCD_SCHED_INIT_SEQ_EN
      init_idx_reg  <= '0;
      single_reg    <= 1'b0;
`endif
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      byte_reg      <= byte_next;
      rs_lat_reg    <= rs_lat_next;
      ptr_reg       <= ptr_next;
      rs_reg        <= rs_next;
      en_reg        <= en_next;
      data_reg      <= data_next;
      busy_reg      <= busy_next;
      init_done_reg <= init_done_next;
`ifdef LCD_SCHED_INIT_SEQ_EN
      init_idx_reg  <= init_idx_next;
      single_reg    <= single_next;
`endif
    end
  end

  assign rs        = rs_reg;
  assign en        = en_reg;
  assign data      = data_reg;
  assign busy      = busy_reg;
  assign init_done = init_done_reg;

endmodule
